axi_ram_slave: RTL and testbench



---
 rtl/axi_ram_slave_if.sv | 75 +++++++
 rtl/axi_ram_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_ram_slave.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between a memory master and axi_ram_slave.
// The write-address (AW) and read-address (AR) sideband fields are carried for completeness; the RAM slave ignores them.
interface axi_ram_slave_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [1:0]          awburst;
    logic [2:0]          awsize;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [1:0]          arburst;
    logic [2:0]          arsize;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awburst, awsize, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arsize, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awburst, awsize, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arsize, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 burst responder over a single-ported RAM; define AXI_RAM_RR_EN for round-robin AW/AR arbitration, else write wins.
// Latency: AW/AR handshake to wready 1 cycle, AR handshake to first rvalid 2 cycles, last W beat to bvalid 1 cycle.
// Backpressure: one burst in flight, AW/AR stall while busy; bvalid/rvalid hold with stable payload until accepted.
module axi_ram_slave #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic           clk,
    input  logic           reset,
    axi_ram_slave_if.slave s_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA} state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [WORD_W-1:0] addr;
        logic [7:0]        len;
        logic              fixed;
    } burst_t;

    state_t            state;
    state_t            state_nxt;
    burst_t            cur;
    logic [7:0]        cnt;
    logic              err;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic aw_sel;
    logic ar_sel;
    logic w_beat;
    logic r_beat;
    logic last_beat;
    logic unused_sideband;

    assign unused_sideband = ^{s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                               s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                               s_axi.awaddr, s_axi.araddr};

`ifdef AXI_RAM_RR_EN
    logic wr_prio;

    assign aw_sel = s_axi.awvalid && (wr_prio || !s_axi.arvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prio <= 1'b1;
        end else if (state == IDLE && aw_sel) begin
            wr_prio <= 1'b0;
        end else if (state == IDLE && ar_sel) begin
            wr_prio <= 1'b1;
        end
    end
`else
    assign aw_sel = s_axi.awvalid;
`endif
    assign ar_sel = s_axi.arvalid && !aw_sel;

    assign last_beat = (cnt == cur.len);
    assign w_beat    = (state == WR_DATA) && s_axi.wvalid;
    assign r_beat    = (state == RD_DATA) && s_axi.rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Readies are masked during reset so no handshake is ever seen that the state will drop.
    always_comb begin
        state_nxt     = state;
        s_axi.awready = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (state)
            IDLE: begin
                s_axi.awready = aw_sel && !reset;
                s_axi.arready = ar_sel && !reset;
                if (aw_sel) begin
                    state_nxt = WR_DATA;
                end else if (ar_sel) begin
                    state_nxt = RD_FETCH;
                end
            end
            WR_DATA: begin
                s_axi.wready = !reset;
                if (s_axi.wvalid && last_beat) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) begin
                    state_nxt = IDLE;
                end
            end
            RD_FETCH: begin
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) begin
                    state_nxt = last_beat ? IDLE : RD_FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s_axi.bid   = cur.id;
    assign s_axi.bresp = (state == WR_RESP && err) ? 2'b10 : 2'b00;
    assign s_axi.rid   = cur.id;
    assign s_axi.rdata = rdata_q;
    assign s_axi.rresp = 2'b00;
    assign s_axi.rlast = (state == RD_DATA) && last_beat;

    // WRAP bursts step like INCR; the word index wraps naturally at the RAM size.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && aw_sel) begin
                cur.id    <= s_axi.awid;
                cur.addr  <= s_axi.awaddr[ADDR_W-1:OFF_W];
                cur.len   <= s_axi.awlen;
                cur.fixed <= (s_axi.awburst == 2'b00);
                cnt       <= '0;
                err       <= 1'b0;
            end else if (state == IDLE && ar_sel) begin
                cur.id    <= s_axi.arid;
                cur.addr  <= s_axi.araddr[ADDR_W-1:OFF_W];
                cur.len   <= s_axi.arlen;
                cur.fixed <= (s_axi.arburst == 2'b00);
                cnt       <= '0;
            end
            if ((w_beat || r_beat) && !last_beat) begin
                cnt <= cnt + 8'd1;
                if (!cur.fixed) begin
                    cur.addr <= cur.addr + 1'b1;
                end
            end
            if (w_beat && (s_axi.wlast != last_beat)) begin
                err <= 1'b1;
            end
            if (state == RD_FETCH) begin
                rdata_q <= mem[cur.addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat && !reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[cur.addr][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomized and directed bench for axi_ram_slave against a byte-level memory model.
module tb_axi_ram_slave;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_ram_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_ram_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .s_axi (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [NWORDS];
    logic [3:0]  ref_kn  [NWORDS];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [15:0] addr, input int beat, input logic [1:0] burst);
        int step;
        step = (burst == 2'b00) ? 0 : beat;
        return (int'(addr) / 4 + step) % NWORDS;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) if (m[k]) r[k*8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic model_write(input logic [15:0] addr, input int beat, input logic [1:0] burst,
                               input logic [31:0] data, input logic [3:0] strb);
        int w;
        w = word_of(addr, beat, burst);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                ref_mem[w][k*8 +: 8] = data[k*8 +: 8];
                ref_kn[w][k] = 1'b1;
            end
        end
    endtask

    task automatic aw_phase(input logic [ID_W-1:0] id, input logic [15:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
        bus.awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
        check("aw_grant", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [ID_W-1:0] id, input logic [15:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
        check("ar_grant", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Called one #1 after the AW handshake edge; wlast is also raised early on beat bad_last.
    task automatic wr_tail(input logic [ID_W-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int bad_last, input int bhold);
        logic [1:0] exp_resp;
        exp_resp = (bad_last >= 0) ? 2'b10 : 2'b00;
        for (int b = 0; b <= int'(len); b++) begin
            bus.wdata = wd[b]; bus.wstrb = ws[b];
            bus.wlast = (b == int'(len)) || (b == bad_last);
            bus.wvalid = 1'b1;
            @(negedge clk);
            check("wready", bus.wready, 1'b1);
            check("bvalid_early", bus.bvalid, 1'b0);
            @(posedge clk); #1;
            model_write(addr, b, burst, wd[b], ws[b]);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        @(negedge clk);
        check("bvalid", bus.bvalid, 1'b1);
        check("bid", bus.bid, id);
        check("bresp", bus.bresp, exp_resp);
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check("bvalid_hold", bus.bvalid, 1'b1);
            check("bresp_hold", bus.bresp, exp_resp);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        check("bvalid_clr", bus.bvalid, 1'b0);
    endtask

    // Called one #1 after the AR handshake edge; each beat shows one fetch cycle then rvalid.
    task automatic rd_tail(input logic [ID_W-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int max_hold);
        int          w;
        int          hold;
        logic [31:0] m;
        for (int b = 0; b <= int'(len); b++) begin
            w    = word_of(addr, b, burst);
            m    = byte_mask(ref_kn[w]);
            hold = int'($urandom_range(max_hold, 0));
            @(negedge clk);
            check("rvalid_fetch", bus.rvalid, 1'b0);
            @(negedge clk);
            check("rvalid", bus.rvalid, 1'b1);
            check("rdata", bus.rdata & m, ref_mem[w] & m);
            check("rid", bus.rid, id);
            check("rlast", bus.rlast, b == int'(len));
            check("rresp", bus.rresp, 2'b00);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("rvalid_hold", bus.rvalid, 1'b1);
                check("rdata_hold", bus.rdata & m, ref_mem[w] & m);
            end
            bus.rready = 1'b1;
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
        @(negedge clk);
        check("rvalid_clr", bus.rvalid, 1'b0);
    endtask

    task automatic rand_burst(input int it);
        logic [15:0]   a;
        logic [7:0]    len;
        logic [1:0]    bt;
        logic [ID_W-1:0] id;
        int            bad;
        a   = 16'($urandom);
        len = 8'($urandom_range(7, 0));
        bt  = 2'($urandom_range(2, 0));
        id  = ID_W'($urandom_range(1, 0));
        bad = -1;
        if (len != 8'd0 && $urandom_range(3, 0) == 0) bad = int'($urandom_range(int'(len) - 1, 0));
        for (int b = 0; b <= int'(len); b++) begin
            wd[b] = $urandom;
            ws[b] = (it % 2 == 1) ? 4'($urandom) : 4'hF;
        end
        aw_phase(id, a, len, bt);
        wr_tail(id, a, len, bt, bad, int'($urandom_range(3, 0)));
        ar_phase(~id, a, len, bt);
        rd_tail(~id, a, len, bt, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            ref_mem[i] = '0;
            ref_kn[i]  = '0;
        end
        reset = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.awsize = 3'd2; bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = 2'b01; bus.arvalid = 1'b0;
        bus.arsize = 3'd2; bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rlast", bus.rlast, 1'b0);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_bid", bus.bid, 1'b0);

        // Single beat write/read.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        aw_phase(1'b1, 16'h0010, 8'd0, 2'b01);
        wr_tail(1'b1, 16'h0010, 8'd0, 2'b01, -1, 0);
        ar_phase(1'b0, 16'h0010, 8'd0, 2'b01);
        rd_tail(1'b0, 16'h0010, 8'd0, 2'b01, 0);

        // INCR burst 1..4 and FIXED burst 5..8.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        aw_phase(1'b0, 16'h0100, 8'd3, 2'b01);
        wr_tail(1'b0, 16'h0100, 8'd3, 2'b01, -1, 1);
        ar_phase(1'b1, 16'h0100, 8'd3, 2'b01);
        rd_tail(1'b1, 16'h0100, 8'd3, 2'b01, 1);
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 5); ws[b] = 4'hF; end
        aw_phase(1'b0, 16'h0200, 8'd3, 2'b00);
        wr_tail(1'b0, 16'h0200, 8'd3, 2'b00, -1, 0);
        ar_phase(1'b0, 16'h0200, 8'd0, 2'b01);
        rd_tail(1'b0, 16'h0200, 8'd0, 2'b01, 0);

        // Byte strobes.
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        aw_phase(1'b0, 16'h0080, 8'd0, 2'b01);
        wr_tail(1'b0, 16'h0080, 8'd0, 2'b01, -1, 0);
        wd[0] = 32'h00000000; ws[0] = 4'h5;
        aw_phase(1'b0, 16'h0080, 8'd0, 2'b01);
        wr_tail(1'b0, 16'h0080, 8'd0, 2'b01, -1, 0);
        ar_phase(1'b0, 16'h0080, 8'd0, 2'b01);
        rd_tail(1'b0, 16'h0080, 8'd0, 2'b01, 0);

        // Early wlast: all four beats still land, SLVERR held under bready stall.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'hC0DE0000 + 32'(b); ws[b] = 4'hF; end
        aw_phase(1'b1, 16'h0400, 8'd3, 2'b01);
        wr_tail(1'b1, 16'h0400, 8'd3, 2'b01, 2, 5);
        ar_phase(1'b1, 16'h0400, 8'd3, 2'b01);
        rd_tail(1'b1, 16'h0400, 8'd3, 2'b01, 0);

        // Simultaneous AW/AR twice in a row.
        wd[0] = 32'hA5A50001; ws[0] = 4'hF;
        @(posedge clk); #1;
        bus.awid = 1'b0; bus.awaddr = 16'h0600; bus.awlen = 8'd0; bus.awburst = 2'b01;
        bus.arid = 1'b1; bus.araddr = 16'h0600; bus.arlen = 8'd0; bus.arburst = 2'b01;
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        @(negedge clk);
        check("arb1_awready", bus.awready, 1'b1);
        check("arb1_arready", bus.arready, 1'b0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        wr_tail(1'b0, 16'h0600, 8'd0, 2'b01, -1, 0);
        wd[0] = 32'hA5A50002;
        bus.awvalid = 1'b1;
        #1;
`ifdef AXI_RAM_RR_EN
        check("arb2_awready", bus.awready, 1'b0);
        check("arb2_arready", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        rd_tail(1'b1, 16'h0600, 8'd0, 2'b01, 0);
`else
        check("arb2_awready", bus.awready, 1'b1);
        check("arb2_arready", bus.arready, 1'b0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        wr_tail(1'b0, 16'h0600, 8'd0, 2'b01, -1, 0);
`endif

        // Reset during beat 2 of a len-7 write.
        for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        aw_phase(1'b1, 16'h0500, 8'd7, 2'b01);
        for (int b = 0; b < 2; b++) begin
            bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = 1'b0; bus.wvalid = 1'b1;
            @(negedge clk);
            check("rstw_wready", bus.wready, 1'b1);
            @(posedge clk); #1;
            model_write(16'h0500, b, 2'b01, wd[b], ws[b]);
        end
        bus.wdata = wd[2]; bus.wvalid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        check("mid_rst_wready", bus.wready, 1'b0);
        check("mid_rst_awready", bus.awready, 1'b0);
        check("mid_rst_arready", bus.arready, 1'b0);
        check("mid_rst_bvalid", bus.bvalid, 1'b0);
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_bid", bus.bid, 1'b0);
        ar_phase(1'b0, 16'h0500, 8'd1, 2'b01);
        rd_tail(1'b0, 16'h0500, 8'd1, 2'b01, 0);

        // INCR burst crossing the top of the address space.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'h57A70000 + 32'(b); ws[b] = 4'hF; end
        aw_phase(1'b0, 16'hFFFC, 8'd3, 2'b01);
        wr_tail(1'b0, 16'hFFFC, 8'd3, 2'b01, -1, 0);
        ar_phase(1'b0, 16'h0000, 8'd2, 2'b01);
        rd_tail(1'b0, 16'h0000, 8'd2, 2'b01, 0);

        for (int it = 0; it < 40; it++) rand_burst(it);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
